color_classifier: RTL and testbench

COLOR_CLASSIFIER -- requirements
Module: color_classifier

---
 rtl/color_classifier.sv | 261 ++++++++++++++++++++++++++
 tb/tb_color_classifier.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/color_classifier.sv
// Colour classifier for a TCS3200-style light-to-frequency sensor: measures red,
// blue and green pulse counts in turn, classifies the surface and files confirmed colours into LED slots.
module color_classifier #(
  parameter int CNT_W      = 10,
  parameter int GATE_CYC   = 256,
  parameter int SETTLE_CYC = 4,
  parameter int MARGIN     = 20,
  parameter int WHITE_TOL  = 15,
  parameter int CONFIRM    = 2,
  parameter int NUM_SLOTS  = 3,
  parameter int HOLD_CYC   = 8000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cs_out,
  input  logic                         enable,
  input  logic [1:0]                   site_id,
  input  logic                         clr_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] clr_idx,
  output logic                         S0,
  output logic                         S1,
  output logic                         S2,
  output logic                         S3,
  output logic                         OE,
  output logic [1:0]                   color,
  output logic                         color_valid,
  output logic [2*NUM_SLOTS-1:0]       slot_color,
  output logic [NUM_SLOTS-1:0]         slot_full,
  output logic                         overflow,
  output logic [2:0]                   dbg_state,
  output logic [CNT_W-1:0]             dbg_r_cnt,
  output logic [CNT_W-1:0]             dbg_b_cnt,
  output logic [CNT_W-1:0]             dbg_g_cnt
);

  localparam int IDX_W    = $clog2(NUM_SLOTS);
  localparam int MEAS_CYC = SETTLE_CYC + GATE_CYC;
  localparam int PH_W     = $clog2(MEAS_CYC);
  localparam int HOLD_W   = $clog2(HOLD_CYC + 1);
  localparam int CONF_W   = $clog2(CONFIRM + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(MEAS_CYC - 1);
  localparam logic [PH_W-1:0]   PH_SETTLE = PH_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W:0]    MARGIN_X  = (CNT_W+1)'(MARGIN);
  localparam logic [CNT_W:0]    TOL_X     = (CNT_W+1)'(WHITE_TOL);
  localparam logic [CONF_W-1:0] CONF_X    = CONF_W'(CONFIRM);
  localparam logic [HOLD_W-1:0] HOLD_X    = HOLD_W'(HOLD_CYC);

  localparam logic [1:0] CLS_NONE  = 2'b00;
  localparam logic [1:0] CLS_RED   = 2'b01;
  localparam logic [1:0] CLS_BLUE  = 2'b10;
  localparam logic [1:0] CLS_GREEN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEAS_R   = 3'd1,
    ST_MEAS_B   = 3'd2,
    ST_MEAS_G   = 3'd3,
    ST_CLASSIFY = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic             cs_meta, cs_sync, cs_prev, cs_edge;
  logic [PH_W-1:0]  cyc_q;
  logic             meas, in_classify, phase_last, count_en;
  logic [CNT_W-1:0] r_cnt, b_cnt, g_cnt;

  logic [CNT_W:0]   r_x, g_x, b_x, mx, sec;
  logic             white;
  logic [1:0]       cls;

  logic [1:0]        cand_q;
  logic [CONF_W-1:0] conf_q, conf_nxt;
  logic [HOLD_W-1:0] hold_q;
  logic [1:0]        last_site;
  logic              site_ok, report;

  logic [NUM_SLOTS-1:0] clr_mask, full_clr, fill_sel;
  logic                 any_empty;

  // Two-flop synchronizer plus a delay stage for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta <= 1'b0;
      cs_sync <= 1'b0;
      cs_prev <= 1'b0;
    end else begin
      cs_meta <= cs_out;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
    end
  end

  assign cs_edge = cs_sync & ~cs_prev;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     state_nxt = ST_MEAS_R;
      ST_MEAS_R:   if (phase_last) state_nxt = ST_MEAS_B;
      ST_MEAS_B:   if (phase_last) state_nxt = ST_MEAS_G;
      ST_MEAS_G:   if (phase_last) state_nxt = ST_CLASSIFY;
      ST_CLASSIFY: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    S0          = 1'b1;
    S1          = 1'b0;
    OE          = 1'b0;
    {S2, S3}    = 2'b10;
    meas        = 1'b0;
    in_classify = 1'b0;
    case (state)
      ST_MEAS_R:   begin {S2, S3} = 2'b00; meas = 1'b1; end
      ST_MEAS_B:   begin {S2, S3} = 2'b01; meas = 1'b1; end
      ST_MEAS_G:   begin {S2, S3} = 2'b11; meas = 1'b1; end
      ST_CLASSIFY: in_classify = 1'b1;
      default:     ;
    endcase
  end

  assign phase_last = meas && (cyc_q == PH_LAST);
  assign count_en   = meas && (cyc_q >= PH_SETTLE);
  assign dbg_state  = state;
  assign dbg_r_cnt  = r_cnt;
  assign dbg_b_cnt  = b_cnt;
  assign dbg_g_cnt  = g_cnt;

  always_ff @(posedge clk) begin
    if (rst || phase_last || !meas) cyc_q <= '0;
    else                            cyc_q <= cyc_q + PH_W'(1);
  end

  // Counters are cleared during the IDLE cycle so MEAS_R always starts from zero.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      r_cnt <= '0;
      b_cnt <= '0;
      g_cnt <= '0;
    end else if (count_en && cs_edge) begin
      case (state)
        ST_MEAS_R: if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
        ST_MEAS_B: if (b_cnt != CNT_MAX) b_cnt <= b_cnt + CNT_W'(1);
        ST_MEAS_G: if (g_cnt != CNT_MAX) g_cnt <= g_cnt + CNT_W'(1);
        default:   ;
      endcase
    end
  end

  // Classification works one bit wider than the counters so margin sums cannot wrap.
  always_comb begin
    r_x = {1'b0, r_cnt};
    g_x = {1'b0, g_cnt};
    b_x = {1'b0, b_cnt};
    if (r_x >= g_x && r_x >= b_x) begin
      mx  = r_x;
      sec = (g_x >= b_x) ? g_x : b_x;
    end else if (g_x >= b_x) begin
      mx  = g_x;
      sec = (r_x >= b_x) ? r_x : b_x;
    end else begin
      mx  = b_x;
      sec = (r_x >= g_x) ? r_x : g_x;
    end
    white = (mx - sec) < TOL_X;
    if (white)                                      cls = CLS_NONE;
    else if (b_x > r_x && b_x > g_x)                cls = CLS_BLUE;
    else if (r_x > g_x + MARGIN_X && r_x > b_x + MARGIN_X) cls = CLS_RED;
    else if (g_x > r_x + MARGIN_X && g_x > b_x + MARGIN_X) cls = CLS_GREEN;
    else                                            cls = CLS_NONE;
  end

  always_comb begin
    conf_nxt = conf_q;
    if (cls == CLS_NONE)
      conf_nxt = '0;
    else if (cls == cand_q && conf_q != '0)
      conf_nxt = (conf_q >= CONF_X) ? conf_q : conf_q + CONF_W'(1);
    else
      conf_nxt = CONF_W'(1);
    site_ok = enable && (site_id != 2'b00);
    report  = in_classify && site_ok && (cls != CLS_NONE) && (conf_nxt >= CONF_X) &&
              (site_id != last_site) && (hold_q == '0);
  end

  // clr_valid is a single-cycle request (no ready); the clear lands before the same cycle's fill.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      clr_mask[i] = clr_valid && (clr_idx == IDX_W'(i));
    full_clr  = slot_full & ~clr_mask;
    fill_sel  = '0;
    any_empty = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!full_clr[i] && !any_empty) begin
        fill_sel[i] = 1'b1;
        any_empty   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      color       <= CLS_NONE;
      color_valid <= 1'b0;
      overflow    <= 1'b0;
      cand_q      <= CLS_NONE;
      conf_q      <= '0;
      hold_q      <= '0;
      last_site   <= 2'b00;
    end else begin
      color_valid <= 1'b0;
      overflow    <= 1'b0;
      if (report)             hold_q <= HOLD_X;
      else if (hold_q != '0)  hold_q <= hold_q - HOLD_W'(1);
      if (site_id == 2'b00)   last_site <= 2'b00;
      else if (report)        last_site <= site_id;
      if (in_classify) begin
        cand_q <= cls;
        if (!site_ok) begin
          conf_q <= '0;
          color  <= CLS_NONE;
        end else if (report) begin
          conf_q      <= '0;
          color       <= cls;
          color_valid <= 1'b1;
          overflow    <= !any_empty;
        end else begin
          conf_q <= conf_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full  <= '0;
      slot_color <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (report && fill_sel[i]) begin
          slot_full[i]        <= 1'b1;
          slot_color[2*i +: 2] <= cls;
        end else if (clr_mask[i]) begin
          slot_full[i]        <= 1'b0;
          slot_color[2*i +: 2] <= CLS_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_color_classifier.sv
// Directed bench for color_classifier: per-filter pulse counts are synthesised on cs_out,
// reports are checked by a scoreboard monitor against hand-computed expectations.
module tb_color_classifier;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_R = 3'd1, ST_B = 3'd2, ST_G = 3'd3, ST_CL = 3'd4;

  logic       clk = 1'b0, rst = 1'b1, cs_out = 1'b0, cs_fast = 1'b0;
  logic       enable = 1'b0, clr_valid = 1'b0;
  logic [1:0] site_id = 2'b00, clr_idx = 2'b00;

  logic       S0, S1, S2, S3, OE, color_valid, overflow;
  logic [1:0] color;
  logic [5:0] slot_color;
  logic [2:0] slot_full, dbg_state;
  logic [9:0] dbg_r_cnt, dbg_b_cnt, dbg_g_cnt;

  logic       s0_2, s1_2, s2_2, s3_2, oe_2, cv_2, ov_2;
  logic [1:0] color_2;
  logic [5:0] sc_2;
  logic [2:0] sf_2, st_2;
  logic [2:0] r_2, b_2, g_2;

  int n_checks = 0, n_errors = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_got, mon_exp;
  int tgt_r = 0, tgt_b = 0, tgt_g = 0;
  int k = 0, n = 0;
  logic [2:0] prev_st = 3'b111;

  // Gate widened to 32 cycles so per-filter counts up to 16 fit in one window.
  color_classifier #(
    .CNT_W(10), .GATE_CYC(32), .SETTLE_CYC(2), .MARGIN(4), .WHITE_TOL(3),
    .CONFIRM(2), .NUM_SLOTS(3), .HOLD_CYC(40)
  ) dut (
    .clk(clk), .rst(rst), .cs_out(cs_out), .enable(enable), .site_id(site_id),
    .clr_valid(clr_valid), .clr_idx(clr_idx),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3), .OE(OE),
    .color(color), .color_valid(color_valid), .slot_color(slot_color),
    .slot_full(slot_full), .overflow(overflow), .dbg_state(dbg_state),
    .dbg_r_cnt(dbg_r_cnt), .dbg_b_cnt(dbg_b_cnt), .dbg_g_cnt(dbg_g_cnt)
  );

  color_classifier #(
    .CNT_W(3), .GATE_CYC(32), .SETTLE_CYC(2), .MARGIN(4), .WHITE_TOL(3),
    .CONFIRM(2), .NUM_SLOTS(3), .HOLD_CYC(40)
  ) dut_sat (
    .clk(clk), .rst(rst), .cs_out(cs_fast), .enable(1'b0), .site_id(2'b00),
    .clr_valid(1'b0), .clr_idx(2'b00),
    .S0(s0_2), .S1(s1_2), .S2(s2_2), .S3(s3_2), .OE(oe_2),
    .color(color_2), .color_valid(cv_2), .slot_color(sc_2),
    .slot_full(sf_2), .overflow(ov_2), .dbg_state(st_2),
    .dbg_r_cnt(r_2), .dbg_b_cnt(b_2), .dbg_g_cnt(g_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void expect_rep(input logic ov, input logic [1:0] c,
                                     input logic [5:0] sc, input logic [2:0] sf);
    exp_q.push_back({1'b1, ov, c, sc, sf});
  endfunction

  // Sensor model: N rising edges at odd cycle offsets of each measurement phase.
  always @(negedge clk) begin
    if (dbg_state != prev_st) k = 0;
    else                      k = k + 1;
    prev_st = dbg_state;
    case (dbg_state)
      ST_R:    n = tgt_r;
      ST_B:    n = tgt_b;
      ST_G:    n = tgt_g;
      default: n = 0;
    endcase
    cs_out  = (k % 2 == 1) && (k < 2 * n);
    cs_fast = ~cs_fast;
  end

  always @(negedge clk) begin
    if (!rst && (color_valid || overflow)) begin
      mon_got = {color_valid, overflow, color, slot_color, slot_full};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_report: got %0h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("report", mon_got, mon_exp);
      end
    end
  end

  task automatic do_round(input int r, input int b, input int g, input logic [1:0] site,
                          input logic en, input logic cv, input logic [1:0] ci);
    int cnt;
    tgt_r = r; tgt_b = b; tgt_g = g;
    site_id = site;
    enable  = en;
    cnt = 0;
    @(negedge clk);
    while (dbg_state !== ST_CL && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 400) begin
      n_checks++;
      n_errors++;
      $display("FAIL round_timeout: got state %0d expected %0d", dbg_state, ST_CL);
    end
    clr_valid = cv;
    clr_idx   = ci;
    check("r_cnt", dbg_r_cnt, r);
    check("b_cnt", dbg_b_cnt, b);
    check("g_cnt", dbg_g_cnt, g);
    @(negedge clk);
    clr_valid = 1'b0;
    clr_idx   = 2'b00;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, dbg_state, ST_IDLE);
    check({tag, "_color"}, color, 2'b00);
    check({tag, "_color_valid"}, color_valid, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_slot_color"}, slot_color, 6'b0);
    check({tag, "_slot_full"}, slot_full, 3'b0);
    check({tag, "_pins"}, {S0, S1, OE, S2, S3}, 5'b10010);
    check({tag, "_counts"}, {dbg_r_cnt, dbg_b_cnt, dbg_g_cnt}, 30'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;

    do_round(4, 12, 6, 2'd1, 1'b1, 1'b0, 2'd0);
    expect_rep(1'b0, 2'b10, 6'b00_00_10, 3'b001);
    do_round(4, 12, 6, 2'd1, 1'b1, 1'b0, 2'd0);
    do_round(10, 2, 9, 2'd1, 1'b1, 1'b0, 2'd0);
    do_round(14, 2, 2, 2'd1, 1'b1, 1'b0, 2'd0);
    do_round(4, 12, 6, 2'd1, 1'b1, 1'b0, 2'd0);
    check("color_kept", color, 2'b10);
    do_round(14, 2, 2, 2'd0, 1'b1, 1'b0, 2'd0);
    check("color_site0", color, 2'b00);

    do_round(14, 2, 2, 2'd1, 1'b1, 1'b0, 2'd0);
    expect_rep(1'b0, 2'b01, 6'b00_01_10, 3'b011);
    do_round(14, 2, 2, 2'd1, 1'b1, 1'b0, 2'd0);
    do_round(14, 2, 2, 2'd1, 1'b1, 1'b0, 2'd0);
    do_round(14, 2, 2, 2'd1, 1'b1, 1'b0, 2'd0);
    do_round(14, 2, 2, 2'd0, 1'b1, 1'b0, 2'd0);
    do_round(14, 2, 2, 2'd1, 1'b1, 1'b0, 2'd0);
    expect_rep(1'b0, 2'b01, 6'b01_01_10, 3'b111);
    do_round(14, 2, 2, 2'd1, 1'b1, 1'b0, 2'd0);

    do_round(3, 2, 13, 2'd0, 1'b1, 1'b0, 2'd0);
    do_round(3, 2, 13, 2'd2, 1'b1, 1'b0, 2'd0);
    expect_rep(1'b1, 2'b11, 6'b01_01_10, 3'b111);
    do_round(3, 2, 13, 2'd2, 1'b1, 1'b0, 2'd0);
    do_round(3, 2, 13, 2'd0, 1'b1, 1'b0, 2'd0);
    do_round(3, 2, 13, 2'd1, 1'b1, 1'b0, 2'd0);
    expect_rep(1'b0, 2'b11, 6'b01_11_10, 3'b111);
    do_round(3, 2, 13, 2'd1, 1'b1, 1'b1, 2'd1);

    do_round(10, 2, 6, 2'd0, 1'b1, 1'b1, 2'd3);
    check("clr_idx_oob_slots", {slot_color, slot_full}, {6'b01_11_10, 3'b111});
    do_round(10, 2, 6, 2'd0, 1'b1, 1'b1, 2'd0);
    check("clr_idx0_slots", {slot_color, slot_full}, {6'b01_11_00, 3'b110});

    do_round(14, 2, 2, 2'd1, 1'b0, 1'b0, 2'd0);
    do_round(14, 2, 2, 2'd1, 1'b1, 1'b0, 2'd0);
    expect_rep(1'b0, 2'b01, 6'b01_11_01, 3'b111);
    do_round(14, 2, 2, 2'd1, 1'b1, 1'b0, 2'd0);

    tgt_r = 5; tgt_b = 5; tgt_g = 5;
    cnt = 0;
    while (dbg_state !== ST_B && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_meas_b", dbg_state, ST_B);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    check("restart_meas_r", dbg_state, ST_R);
    check("restart_filter", {S2, S3}, 2'b00);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int cnt;
    cnt = 0;
    while (rst && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (st_2 !== ST_CL && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("sat_state", st_2, ST_CL);
    check("sat_r", r_2, 3'd7);
    check("sat_b", b_2, 3'd7);
    check("sat_g", g_2, 3'd7);
  end

endmodule
